// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared memory-access types and constants for the core data path
package riscv_pkg;

    localparam int DMEM_SIZE      = 256;
    localparam int DMEM_ARB_PORTS = 2;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef struct packed {
        logic        write;
        mem_size_e   size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_rsp_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - per-port request/response bundle between requesters and the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int NPORTS = riscv_pkg::DMEM_ARB_PORTS
);
    import riscv_pkg::*;

    logic [NPORTS-1:0] req_valid;
    logic [NPORTS-1:0] req_ready;
    logic [NPORTS-1:0] req_write;
    mem_size_e         req_size  [NPORTS];
    logic [NPORTS-1:0] req_unsigned;
    logic [31:0]       req_addr  [NPORTS];
    logic [31:0]       req_wdata [NPORTS];

    logic [NPORTS-1:0] rsp_valid;
    logic [NPORTS-1:0] rsp_ready;
    logic [31:0]       rsp_rdata [NPORTS];
    logic [NPORTS-1:0] rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_arbiter_align_check.sv
// rtl/dmem_arbiter_align_check.sv - combinational misalignment / out-of-range detector for one access
module dmem_align_check
    import riscv_pkg::*;
#(
    parameter int ADDR_LIMIT = DMEM_SIZE * 4
) (
    input  mem_size_e   size,
    input  logic [31:0] addr,
    output logic        err
);

    logic align_err;

    always_comb begin
        align_err = 1'b0;
        case (size)
            MEM_BYTE: align_err = 1'b0;
            MEM_HALF: align_err = addr[0];
            MEM_WORD: align_err = (addr[1:0] != 2'b00);
            default:  align_err = 1'b1;
        endcase
    end

    assign err = align_err || (addr >= 32'(ADDR_LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter/sequencer in front of the single-port data memory
module dmem_arbiter
    import riscv_pkg::*;
#(
    parameter int NPORTS     = DMEM_ARB_PORTS,
    parameter int STARVE_MAX = 4,
    parameter int ADDR_LIMIT = DMEM_SIZE * 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus,
    output logic           mem_read,
    output logic           mem_write,
    output mem_size_e      mem_size,
    output logic           unsigned_load,
    output logic [31:0]    data_addr,
    output logic [31:0]    data_write_data,
    input  logic [31:0]    data_read_data
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [NPORTS-1:0] eligible;
    logic [NPORTS-1:0] grant;
    logic [CW-1:0]     starve_cnt;
    dmem_req_t         req [NPORTS];
    dmem_req_t         sel;
    logic              has_grant;
    logic              sel_err;

    for (genvar p = 0; p < NPORTS; p++) begin : g_in
        assign req[p] = '{write:       bus.req_write[p],
                          size:        bus.req_size[p],
                          is_unsigned: bus.req_unsigned[p],
                          addr:        bus.req_addr[p],
                          wdata:       bus.req_wdata[p]};
        // A port may issue while its own slot is free or is being drained this cycle.
        assign eligible[p] = bus.req_valid[p] && (!bus.rsp_valid[p] || bus.rsp_ready[p]);
    end

    always_comb begin
        grant = '0;
        if (eligible[0] && eligible[1]) begin
            grant = (starve_cnt == CW'(STARVE_MAX)) ? NPORTS'(2) : NPORTS'(1);
        end else begin
            grant = eligible;
        end
    end

    assign bus.req_ready = grant;
    assign has_grant     = |grant;
    assign sel           = grant[1] ? req[1] : req[0];

    dmem_align_check #(
        .ADDR_LIMIT(ADDR_LIMIT)
    ) u_align_check (
        .size (sel.size),
        .addr (sel.addr),
        .err  (sel_err)
    );

    // Reset gates the strobes so a grant coincident with reset never reaches memory.
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_size        = MEM_BYTE;
        unsigned_load   = 1'b0;
        data_addr       = '0;
        data_write_data = '0;
        if (has_grant) begin
            mem_read        = !sel.write && !sel_err && !rst;
            mem_write       = sel.write && !sel_err && !rst;
            mem_size        = sel.size;
            unsigned_load   = sel.is_unsigned;
            data_addr       = sel.addr;
            data_write_data = sel.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant[1] || !eligible[1]) begin
            starve_cnt <= '0;
        end else if (grant[0] && (starve_cnt != CW'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_rsp
        logic      valid_q;
        dmem_rsp_t rsp_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                rsp_q   <= '0;
            end else if (grant[p]) begin
                valid_q     <= 1'b1;
                rsp_q.err   <= sel_err;
                rsp_q.rdata <= (!sel.write && !sel_err) ? data_read_data : '0;
            end else if (bus.rsp_ready[p]) begin
                valid_q <= 1'b0;
            end
        end

        assign bus.rsp_valid[p] = valid_q;
        assign bus.rsp_rdata[p] = rsp_q.rdata;
        assign bus.rsp_err[p]   = rsp_q.err;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter with a byte-array memory model
module tb_dmem_arbiter;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    mem_size_e   mem_size;
    logic        unsigned_load;
    logic [31:0] data_addr;
    logic [31:0] data_write_data;
    logic [31:0] data_read_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.NPORTS(2)) bus ();

    dmem_arbiter #(
        .NPORTS(2),
        .STARVE_MAX(4),
        .ADDR_LIMIT(1024)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_size        (mem_size),
        .unsigned_load   (unsigned_load),
        .data_addr       (data_addr),
        .data_write_data (data_write_data),
        .data_read_data  (data_read_data)
    );

    logic [7:0] mem_b [0:1023];
    logic [9:0] ma;
    assign ma = data_addr[9:0];

    always_comb begin
        case (mem_size)
            MEM_BYTE: data_read_data = {{24{mem_b[ma][7] & ~unsigned_load}}, mem_b[ma]};
            MEM_HALF: data_read_data = {{16{mem_b[10'(ma + 1)][7] & ~unsigned_load}},
                                        mem_b[10'(ma + 1)], mem_b[ma]};
            default:  data_read_data = {mem_b[10'(ma + 3)], mem_b[10'(ma + 2)],
                                        mem_b[10'(ma + 1)], mem_b[ma]};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem_b[ma] <= data_write_data[7:0];
            if (mem_size != MEM_BYTE) mem_b[10'(ma + 1)] <= data_write_data[15:8];
            if (mem_size == MEM_WORD) begin
                mem_b[10'(ma + 2)] <= data_write_data[23:16];
                mem_b[10'(ma + 3)] <= data_write_data[31:24];
            end
        end
    end

    task automatic access(input int p, input logic w, input mem_size_e sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output logic rd_seen, output logic wr_seen);
        int n;
        bus.req_write[p]    = w;
        bus.req_size[p]     = sz;
        bus.req_unsigned[p] = u;
        bus.req_addr[p]     = a;
        bus.req_wdata[p]    = wd;
        bus.req_valid[p]    = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[p] && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (bus.req_ready[p] !== 1'b1) begin
            errors++;
            $display("FAIL grant_timeout port %0d addr %h: req_ready %b, required 1", p, a, bus.req_ready[p]);
        end
        rd_seen = mem_read;
        wr_seen = mem_write;
        @(posedge clk); #1;
        bus.req_valid[p] = 1'b0;
        checks++;
        if (bus.rsp_valid[p] !== 1'b1) begin
            errors++;
            $display("FAIL rsp_latency port %0d addr %h: rsp_valid %b, required 1", p, a, bus.rsp_valid[p]);
        end
        rd = bus.rsp_rdata[p];
        er = bus.rsp_err[p];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 2'b11;
        for (int p = 0; p < 2; p++) begin
            bus.req_write[p] = 1'b0; bus.req_size[p] = MEM_WORD; bus.req_unsigned[p] = 1'b0;
            bus.req_addr[p] = '0; bus.req_wdata[p] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 00", bus.rsp_valid); end
        checks++;
        if (bus.rsp_err !== 2'b00) begin errors++; $display("FAIL reset_rsp_err: got %b, required 00", bus.rsp_err); end
        checks++;
        if (bus.rsp_rdata[0] !== 32'h0 || bus.rsp_rdata[1] !== 32'h0) begin
            errors++; $display("FAIL reset_rsp_rdata: got %h/%h, required 0/0", bus.rsp_rdata[0], bus.rsp_rdata[1]);
        end
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || bus.req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_idle: rd %b wr %b ready %b, required 0 0 00", mem_read, mem_write, bus.req_ready);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er, rs, ws;
        access(0, 1'b1, MEM_WORD, 1'b0, 32'h10, 32'h1234_5678, rd, er, rs, ws);
        checks++;
        if (ws !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL sw_basic: wr %b err %b rdata %h, required 1 0 0", ws, er, rd);
        end
        access(0, 1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, rd, er, rs, ws);
        checks++;
        if (rs !== 1'b1 || er !== 1'b0 || rd !== 32'h1234_5678) begin
            errors++; $display("FAIL lw_basic: rd %b err %b rdata %h, required 1 0 12345678", rs, er, rd);
        end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er, rs, ws;
        access(0, 1'b1, MEM_WORD, 1'b0, 32'h20, 32'h8001_1234, rd, er, rs, ws);
        access(0, 1'b1, MEM_BYTE, 1'b0, 32'h21, 32'h0000_0080, rd, er, rs, ws);
        access(0, 1'b0, MEM_BYTE, 1'b0, 32'h21, 32'h0, rd, er, rs, ws);
        checks++;
        if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin errors++; $display("FAIL lb_sign: got %h err %b, required ffffff80 0", rd, er); end
        access(0, 1'b0, MEM_BYTE, 1'b1, 32'h21, 32'h0, rd, er, rs, ws);
        checks++;
        if (rd !== 32'h0000_0080 || er !== 1'b0) begin errors++; $display("FAIL lbu_zero: got %h err %b, required 00000080 0", rd, er); end
        access(0, 1'b0, MEM_HALF, 1'b0, 32'h22, 32'h0, rd, er, rs, ws);
        checks++;
        if (rd !== 32'hFFFF_8001 || er !== 1'b0) begin errors++; $display("FAIL lh_sign: got %h err %b, required ffff8001 0", rd, er); end
        access(0, 1'b0, MEM_WORD, 1'b0, 32'h20, 32'h0, rd, er, rs, ws);
        checks++;
        if (rd !== 32'h8001_8034) begin errors++; $display("FAIL sb_merge: got %h, required 80018034", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, rs, ws;
        access(0, 1'b1, MEM_WORD, 1'b0, 32'h13, 32'hFFFF_FFFF, rd, er, rs, ws);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || ws !== 1'b0 || rs !== 1'b0) begin
            errors++; $display("FAIL sw_misaligned: err %b rdata %h wr %b rd %b, required 1 0 0 0", er, rd, ws, rs);
        end
        access(1, 1'b0, MEM_HALF, 1'b0, 32'h01, 32'h0, rd, er, rs, ws);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || rs !== 1'b0 || ws !== 1'b0) begin
            errors++; $display("FAIL lh_misaligned: err %b rdata %h rd %b wr %b, required 1 0 0 0", er, rd, rs, ws);
        end
        access(0, 1'b0, MEM_WORD, 1'b0, 32'd1024, 32'h0, rd, er, rs, ws);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || rs !== 1'b0) begin
            errors++; $display("FAIL lw_limit: err %b rdata %h rd %b, required 1 0 0", er, rd, rs);
        end
        access(0, 1'b1, mem_size_e'(2'b11), 1'b0, 32'h10, 32'hAAAA_AAAA, rd, er, rs, ws);
        checks++;
        if (er !== 1'b1 || ws !== 1'b0) begin errors++; $display("FAIL size_reserved: err %b wr %b, required 1 0", er, ws); end
        access(0, 1'b0, MEM_WORD, 1'b0, 32'd1020, 32'h0, rd, er, rs, ws);
        checks++;
        if (er !== 1'b0 || rs !== 1'b1) begin errors++; $display("FAIL lw_last_word: err %b rd %b, required 0 1", er, rs); end
        access(0, 1'b0, MEM_WORD, 1'b0, 32'h10, 32'h0, rd, er, rs, ws);
        checks++;
        if (rd !== 32'h1234_5678 || er !== 1'b0) begin errors++; $display("FAIL err_readback: got %h, required 12345678", rd); end
    endtask

    task automatic test_starve();
        logic [1:0] exp;
        bus.rsp_ready = 2'b11;
        for (int p = 0; p < 2; p++) begin
            bus.req_write[p] = 1'b0; bus.req_size[p] = MEM_WORD; bus.req_unsigned[p] = 1'b0;
            bus.req_addr[p] = (p == 0) ? 32'h10 : 32'h20;
        end
        bus.req_valid = 2'b11;
        #1;
        for (int i = 0; i < 10; i++) begin
            exp = (i % 5 == 4) ? 2'b10 : 2'b01;
            checks++;
            if (bus.req_ready !== exp) begin
                errors++; $display("FAIL starve_pattern cycle %0d: req_ready %b, required %b", i, bus.req_ready, exp);
            end
            @(posedge clk); #2;
        end
        bus.req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        bus.req_write[0] = 1'b0; bus.req_size[0] = MEM_WORD; bus.req_unsigned[0] = 1'b0; bus.req_addr[0] = 32'h10;
        bus.req_write[1] = 1'b0; bus.req_size[1] = MEM_WORD; bus.req_unsigned[1] = 1'b0; bus.req_addr[1] = 32'h20;
        bus.rsp_ready = 2'b10;
        bus.req_valid = 2'b01;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_first_grant: req_ready %b, required 01", bus.req_ready); end
        @(posedge clk); #1;
        held = 32'h1234_5678;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_rdata[0] !== held) begin
                errors++; $display("FAIL bp_hold cycle %0d: valid %b rdata %h, required 1 %h", i, bus.rsp_valid[0], bus.rsp_rdata[0], held);
            end
            checks++;
            if (bus.req_ready !== 2'b10) begin
                errors++; $display("FAIL bp_cross_grant cycle %0d: req_ready %b, required 10", i, bus.req_ready);
            end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_release: req_ready %b, required 01", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        checks++;
        if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_rdata[0] !== held) begin
            errors++; $display("FAIL bp_reload: valid %b rdata %h, required 1 %h", bus.rsp_valid[0], bus.rsp_rdata[0], held);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL bp_drain: rsp_valid %b, required 00", bus.rsp_valid); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er, rs, ws;
        access(0, 1'b1, MEM_WORD, 1'b0, 32'h40, 32'hCAFE_F00D, rd, er, rs, ws);
        bus.req_write[1] = 1'b1; bus.req_size[1] = MEM_WORD; bus.req_unsigned[1] = 1'b0;
        bus.req_addr[1] = 32'h40; bus.req_wdata[1] = 32'hDEAD_BEEF;
        bus.req_valid[1] = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b, required 0", mem_write); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_valid = 2'b00;
        checks++;
        if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL rst_rsp_valid: got %b, required 00", bus.rsp_valid); end
        access(1, 1'b0, MEM_WORD, 1'b0, 32'h40, 32'h0, rd, er, rs, ws);
        checks++;
        if (rd !== 32'hCAFE_F00D || er !== 1'b0) begin errors++; $display("FAIL rst_readback: got %h, required cafef00d", rd); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
        test_reset();
        test_basic();
        test_subword();
        test_errors();
        test_starve();
        test_backpressure();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
